// File: rtl/cvxif_result_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cvxif_result_queue                                              |
// | Brief    : In-order coprocessor result buffer released on core commit.     |
// |            Optional macro CVXIF_RESULT_QUEUE_KILL_FILTER_EN drops killed   |
// |            results instead of forwarding them.                             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

package cvxif_pkg;
    localparam int X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  x_commit_kill;
    } x_commit_t;
endpackage

module cvxif_result_queue
    import cvxif_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NumIds = 2**cvxif_pkg::X_ID_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     cp_result_valid_i,
    output logic                     cp_result_ready_o,
    input  x_result_t                cp_result_i,
    input  logic                     x_commit_valid_i,
    input  x_commit_t                x_commit_i,
    output logic                     core_result_valid_o,
    input  logic                     core_result_ready_i,
    output x_result_t                core_result_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int               c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full  = (c_addr_w+1)'(DEPTH);

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_WAIT,
        HEAD_READY,
        HEAD_DROP
    } head_state_e;

    x_result_t             r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;
    logic [NumIds-1:0]     r_committed;
    logic [NumIds-1:0]     w_committed_nxt;

    x_result_t             w_head;
    head_state_e           w_head_state;
    logic                  w_push;
    logic                  w_pop;

    assign w_head = r_mem[r_rd_ptr];

`ifdef CVXIF_RESULT_QUEUE_KILL_FILTER_EN
    logic [NumIds-1:0]     r_killed;
    logic [NumIds-1:0]     w_killed_nxt;
`else
    logic                  w_unused_kill;
    assign w_unused_kill = x_commit_i.x_commit_kill;
`endif

    always_comb begin
        w_head_state = HEAD_EMPTY;
        if (r_count != '0) begin
            if (!r_committed[w_head.id]) begin
                w_head_state = HEAD_WAIT;
            end
`ifdef CVXIF_RESULT_QUEUE_KILL_FILTER_EN
            else if (r_killed[w_head.id]) begin
                w_head_state = HEAD_DROP;
            end
`endif
            else begin
                w_head_state = HEAD_READY;
            end
        end
    end

    // Space is judged on the registered count only, so a full queue never
    // accepts a push even when the head leaves in the same cycle.
    assign cp_result_ready_o   = (r_count != c_full);
    assign w_push              = cp_result_valid_i && cp_result_ready_o;
    assign w_pop               = ((w_head_state == HEAD_READY) && core_result_ready_i)
                               || (w_head_state == HEAD_DROP);
    assign core_result_valid_o = (w_head_state == HEAD_READY);
    assign core_result_o       = (r_count != '0) ? w_head : '0;
    assign usage_o             = r_count;

    // Consuming the head clears its status; a same-cycle commit wins.
    always_comb begin
        w_committed_nxt = r_committed;
        if (w_pop) begin
            w_committed_nxt[w_head.id] = 1'b0;
        end
        if (x_commit_valid_i) begin
            w_committed_nxt[x_commit_i.id] = 1'b1;
        end
    end

`ifdef CVXIF_RESULT_QUEUE_KILL_FILTER_EN
    always_comb begin
        w_killed_nxt = r_killed;
        if (w_pop) begin
            w_killed_nxt[w_head.id] = 1'b0;
        end
        if (x_commit_valid_i && x_commit_i.x_commit_kill) begin
            w_killed_nxt[x_commit_i.id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_killed <= '0;
        end else if (flush_i) begin
            r_killed <= '0;
        end else begin
            r_killed <= w_killed_nxt;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_committed <= '0;
        end else if (flush_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_committed <= '0;
        end else begin
            r_committed <= w_committed_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cp_result_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_result_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cvxif_result_queue                                           |
// | Brief    : Randomized and directed bench for cvxif_result_queue against a |
// |            queue-based model of commit-gated in-order release.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module tb_cvxif_result_queue;
    import cvxif_pkg::*;

    localparam int DEPTH = 4;
    localparam int NIDS  = 2**X_ID_WIDTH;
`ifdef CVXIF_RESULT_QUEUE_KILL_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  flush_i = 1'b0;
    logic                  cp_result_valid_i = 1'b0;
    logic                  cp_result_ready_o;
    x_result_t             cp_result_i = '0;
    logic                  x_commit_valid_i = 1'b0;
    x_commit_t             x_commit_i = '0;
    logic                  core_result_valid_o;
    logic                  core_result_ready_i = 1'b0;
    x_result_t             core_result_o;
    logic [$clog2(DEPTH):0] usage_o;

    cvxif_result_queue #(.DEPTH(DEPTH), .NumIds(NIDS)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .cp_result_valid_i   (cp_result_valid_i),
        .cp_result_ready_o   (cp_result_ready_o),
        .cp_result_i         (cp_result_i),
        .x_commit_valid_i    (x_commit_valid_i),
        .x_commit_i          (x_commit_i),
        .core_result_valid_o (core_result_valid_o),
        .core_result_ready_i (core_result_ready_i),
        .core_result_o       (core_result_o),
        .usage_o             (usage_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: an ordered list of held results plus per-ID commit/kill flags.
    x_result_t mq[$];
    bit        st_commit [NIDS];
    bit        st_kill   [NIDS];
    int        n_vec = 0;
    int        n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic x_result_t make_res(int id, logic [31:0] data);
        x_result_t r;
        r.id      = id[X_ID_WIDTH-1:0];
        r.data    = data;
        r.rd      = data[4:0];
        r.we      = data[5];
        r.exc     = data[6];
        r.exccode = data[12:7];
        return r;
    endfunction

    function automatic bit in_queue(logic [X_ID_WIDTH-1:0] id);
        foreach (mq[i]) if (mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        foreach (st_commit[i]) begin
            st_commit[i] = 1'b0;
            st_kill[i]   = 1'b0;
        end
    endtask

    task automatic check_outputs();
        x_result_t e = '0;
        bit        ev = 1'b0;
        if (mq.size() > 0) begin
            e  = mq[0];
            ev = st_commit[e.id] && !(FILTER && st_kill[e.id]);
        end
        check("valid", 64'(core_result_valid_o), 64'(ev));
        check("result", 64'(core_result_o), 64'(e));
        check("cp_ready", 64'(cp_result_ready_o), 64'(mq.size() != DEPTH));
        check("usage", 64'(usage_o), 64'(mq.size()));
    endtask

    // One clock: check outputs, drive inputs, advance the model, cross the edge.
    task automatic step(bit push, x_result_t res, bit cv, int cid, bit kill, bit rdy, bit fl);
        logic [X_ID_WIDTH-1:0] hid;
        bit                    full;
        check_outputs();
        cp_result_valid_i          = push;
        cp_result_i                = res;
        x_commit_valid_i           = cv;
        x_commit_i.id              = cid[X_ID_WIDTH-1:0];
        x_commit_i.x_commit_kill   = kill;
        core_result_ready_i        = rdy;
        flush_i                    = fl;
        if (fl) begin
            model_clear();
        end else begin
            full = (mq.size() == DEPTH);
            if (mq.size() > 0) begin
                hid = mq[0].id;
                if (st_commit[hid] && ((FILTER && st_kill[hid]) || rdy)) begin
                    void'(mq.pop_front());
                    st_commit[hid] = 1'b0;
                    st_kill[hid]   = 1'b0;
                end
            end
            if (cv) begin
                st_commit[cid] = 1'b1;
                if (kill) st_kill[cid] = 1'b1;
            end
            if (push && !full) mq.push_back(res);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        model_clear();
        #1;
        check("rst_valid", 64'(core_result_valid_o), 64'd0);
        check("rst_result", 64'(core_result_o), 64'd0);
        check("rst_ready", 64'(cp_result_ready_o), 64'd1);
        check("rst_usage", 64'(usage_o), 64'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Commit before push, then forward and pop.
        step(1'b0, '0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, make_res(3, 32'h2A), 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("early_commit_data", 64'(core_result_o.data), 64'h2A);
        idle(2, 1'b1);
        check("early_commit_empty", 64'(usage_o), 64'd0);

        // Out-of-order commits still release in FIFO order.
        step(1'b1, make_res(1, 32'h11), 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b1, make_res(2, 32'h22), 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill, commit under backpressure, hold, then drain back to back.
        for (int i = 0; i < 5; i++) step(1'b1, make_res(6 + i, $urandom), 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("full_ready", 64'(cp_result_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 6 + i, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Killed result: dropped with the filter, forwarded without it.
        step(1'b1, make_res(5, 32'h55), 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Flush discards entries and pending status; reused ID waits again.
        step(1'b0, '0, 1'b1, 12, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, make_res(12 + i, $urandom), 1'b1, 13 + i, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("flush_usage", 64'(usage_o), 64'd0);
        check("flush_valid", 64'(core_result_valid_o), 64'd0);
        step(1'b1, make_res(12, 32'hC0), 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        check("reuse_waits", 64'(core_result_valid_o), 64'd0);
        step(1'b0, '0, 1'b1, 12, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) step(1'b1, make_res(i, $urandom), 1'b1, i, 1'b0, 1'b1, 1'b0);
        cp_result_valid_i = 1'b0;
        x_commit_valid_i  = 1'b0;
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(core_result_valid_o), 64'd0);
        check("arst_result", 64'(core_result_o), 64'd0);
        check("arst_ready", 64'(cp_result_ready_o), 64'd1);
        check("arst_usage", 64'(usage_o), 64'd0);
        model_clear();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        idle(2, 1'b1);

        // Randomized traffic respecting the unique-outstanding-ID rule.
        for (int c = 0; c < 3000; c++) begin
            x_result_t r;
            bit        p, cv, k, rdy, fl;
            int        cid;
            r   = make_res($urandom_range(0, NIDS - 1), $urandom);
            p   = ($urandom_range(0, 99) < 55) && !in_queue(r.id);
            cid = $urandom_range(0, NIDS - 1);
            cv  = ($urandom_range(0, 99) < 45) && !st_commit[cid];
            k   = ($urandom_range(0, 99) < 25);
            rdy = ($urandom_range(0, 99) < 70);
            fl  = ($urandom_range(0, 199) == 0);
            step(p, r, cv, cid, k, rdy, fl);
        end
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
